eq_gain_mixer: RTL and testbench

Consumer-side recombination stage for the 10-band FIR filter bank. It captures one sample from each band output on a sample strobe and applies a programmable signed gain per band. A single time-multiplexed multiplier-accumulator then sums the weighted bands and emits one rounded, saturated 24-bit equalised sample with a valid pulse. It sits directly downstream of `fir_all_filters` and replaces its fixed unity `o_sum` with a gain-controlled mix.

---
 rtl/eq_gain_mixer.sv | 150 +++++++++++++++
 tb/tb_eq_gain_mixer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_mixer.sv
// eq_gain_mixer: captures one sample from each of the 10 filter-bank bands,
// weights each by a programmable signed gain through a single time-shared MAC,
// and emits a rounded, saturated equalised sample with a valid pulse.
module eq_gain_mixer #(
  parameter int DATA_W    = 24,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 14,
  parameter int ACC_W     = DATA_W + GAIN_W + 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_lp,
  input  logic [DATA_W-1:0] i_band_64_125,
  input  logic [DATA_W-1:0] i_band_125_250,
  input  logic [DATA_W-1:0] i_band_250_500,
  input  logic [DATA_W-1:0] i_band_500_1k,
  input  logic [DATA_W-1:0] i_band_1k_2k,
  input  logic [DATA_W-1:0] i_band_2k_4k,
  input  logic [DATA_W-1:0] i_band_4k_8k,
  input  logic [DATA_W-1:0] i_band_8k_16k,
  input  logic [DATA_W-1:0] i_hp,
  input  logic              i_gain_we,
  input  logic [3:0]        i_gain_addr,
  input  logic [GAIN_W-1:0] i_gain_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_sat,
  output logic              o_busy,
  output logic              o_drop,
  output logic              o_wr_err
);

  localparam int NB     = 10;
  localparam int PROD_W = DATA_W + GAIN_W;

  localparam logic signed [GAIN_W-1:0] UNITY   = GAIN_W'(2 ** GAIN_FRAC);
  localparam logic signed [ACC_W-1:0]  HALF    = ACC_W'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [DATA_W-1:0] MAX_D   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D   = ~MAX_D;
  localparam logic signed [ACC_W-1:0]  MAX_OUT = ACC_W'(MAX_D);
  localparam logic signed [ACC_W-1:0]  MIN_OUT = ACC_W'(MIN_D);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

  state_t                     state, state_nxt;
  logic [3:0]                 idx;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   bank [NB];
  logic signed [GAIN_W-1:0]   gain [NB];
  logic [DATA_W-1:0]          band_in [NB];
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    rnd;
  logic                       busy;
  logic                       gain_ok;

  // Round half toward +infinity, dropping the gain fraction bits.
  function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a + HALF;
    return s >>> GAIN_FRAC;
  endfunction

  // True when the rounded value lies outside the output sample range.
  function automatic logic is_clipped(input logic signed [ACC_W-1:0] r);
    return (r > MAX_OUT) || (r < MIN_OUT);
  endfunction

  // Clamp the rounded value into the output sample range.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] r);
    if (r > MAX_OUT) return MAX_D;
    if (r < MIN_OUT) return MIN_D;
    return r[DATA_W-1:0];
  endfunction

  assign band_in[0] = i_lp;
  assign band_in[1] = i_band_64_125;
  assign band_in[2] = i_band_125_250;
  assign band_in[3] = i_band_250_500;
  assign band_in[4] = i_band_500_1k;
  assign band_in[5] = i_band_1k_2k;
  assign band_in[6] = i_band_2k_4k;
  assign band_in[7] = i_band_4k_8k;
  assign band_in[8] = i_band_8k_16k;
  assign band_in[9] = i_hp;

  assign busy     = (state != S_IDLE);
  assign o_busy   = busy;
  assign gain_ok  = i_gain_we && !busy && (i_gain_addr <= 4'd9);
  assign prod     = PROD_W'(bank[idx]) * PROD_W'(gain[idx]);
  assign prod_ext = ACC_W'(prod);
  assign rnd      = round_acc(acc);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: capture, ten MAC cycles, one round/saturate cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_en) state_nxt = S_MAC;
      S_MAC:   if (idx == 4'd9) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath, gain bank and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx      <= '0;
      acc      <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_sat    <= 1'b0;
      o_drop   <= 1'b0;
      o_wr_err <= 1'b0;
      for (int i = 0; i < NB; i++) gain[i] <= UNITY;
    end else begin
      o_valid  <= 1'b0;
      o_drop   <= i_en && busy;
      o_wr_err <= i_gain_we && !gain_ok;
      if (gain_ok) gain[i_gain_addr] <= $signed(i_gain_data);
      case (state)
        S_IDLE: begin
          if (i_en) begin
            for (int i = 0; i < NB; i++) bank[i] <= $signed(band_in[i]);
            acc <= '0;
            idx <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 4'd1;
        end
        S_ROUND: begin
          o_data  <= saturate(rnd);
          o_sat   <= is_clipped(rnd);
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_gain_mixer.sv
// Bench for eq_gain_mixer: directed cases plus random mixes, with a
// scoreboard queue fed at capture time and drained by an output monitor.
module tb_eq_gain_mixer;

  localparam int DATA_W = 24;
  localparam int GAIN_W = 16;

  logic              clk = 1'b0;
  logic              rst, en, gwe;
  logic [3:0]        gaddr;
  logic [GAIN_W-1:0] gdata;
  logic [DATA_W-1:0] band [10];
  logic [DATA_W-1:0] o_data;
  logic              o_valid, o_sat, o_busy, o_drop, o_wr_err;

  always #5 clk = ~clk;

  eq_gain_mixer dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_lp(band[0]), .i_band_64_125(band[1]), .i_band_125_250(band[2]),
    .i_band_250_500(band[3]), .i_band_500_1k(band[4]), .i_band_1k_2k(band[5]),
    .i_band_2k_4k(band[6]), .i_band_4k_8k(band[7]), .i_band_8k_16k(band[8]),
    .i_hp(band[9]),
    .i_gain_we(gwe), .i_gain_addr(gaddr), .i_gain_data(gdata),
    .o_data(o_data), .o_valid(o_valid), .o_sat(o_sat), .o_busy(o_busy),
    .o_drop(o_drop), .o_wr_err(o_wr_err)
  );

  typedef struct {
    int data;
    bit sat;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   gm[10];
  int   bv[10];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference: weighted sum, divide by 2^14 rounding half up, clamp to 24 bits.
  function automatic exp_t model();
    exp_t   e;
    longint s = 0;
    longint r;
    for (int i = 0; i < 10; i++) s += longint'(bv[i]) * longint'(gm[i]);
    r = (s + 8192) >>> 14;
    e.sat = 1'b0;
    if (r > 8388607)       begin r = 8388607;  e.sat = 1'b1; end
    else if (r < -8388608) begin r = -8388608; e.sat = 1'b1; end
    e.data = int'(r);
    e.cyc  = 0;
    return e;
  endfunction

  // Output monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (o_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got o_data=%0d with no mix outstanding", $signed(o_data));
      end else begin
        e = sbq.pop_front();
        check("o_data", longint'($signed(o_data)), e.data);
        check("o_sat", o_sat, e.sat);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(int v);
    for (int i = 0; i < 10; i++) bv[i] = v;
  endtask

  task automatic set_unity();
    for (int i = 0; i < 10; i++) gm[i] = 16384;
  endtask

  // Present bands with a one-cycle strobe; result due 11 edges after capture.
  task automatic start_mix();
    exp_t e;
    for (int i = 0; i < 10; i++) band[i] = bv[i][DATA_W-1:0];
    e = model();
    e.cyc = cyc + 12;
    sbq.push_back(e);
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic write_gain(int a, int g, bit busy_now);
    bit ok;
    gwe   = 1'b1;
    gaddr = a[3:0];
    gdata = g[GAIN_W-1:0];
    tick();
    gwe = 1'b0;
    ok = !busy_now && (a <= 9);
    if (ok) gm[a] = g;
    check("o_wr_err", o_wr_err, !ok);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!o_busy && sbq.size() == 0) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_idle: still busy=%0d pending=%0d, expected idle", o_busy, sbq.size());
    sbq.delete();
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_o_data"}, o_data, 0);
    check({tag, "_o_valid"}, o_valid, 0);
    check({tag, "_o_sat"}, o_sat, 0);
    check({tag, "_o_busy"}, o_busy, 0);
    check({tag, "_o_drop"}, o_drop, 0);
    check({tag, "_o_wr_err"}, o_wr_err, 0);
  endtask

  initial begin
    int nb;
    logic [23:0] t24;
    logic [15:0] t16;
    rst = 1'b1; en = 1'b0; gwe = 1'b0; gaddr = '0; gdata = '0;
    for (int i = 0; i < 10; i++) band[i] = '0;
    set_unity();
    repeat (3) tick();
    rst = 1'b0;
    check_zero_outputs("reset");

    // Unity sum and busy duration
    fill(1000);
    start_mix();
    nb = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!o_busy) break;
      nb++;
    end
    check("busy_cycles", nb - 1, 11);
    #1;
    wait_idle();
    repeat (2) tick();
    check("hold_o_data", longint'($signed(o_data)), 10000);

    // Rounding half toward +infinity
    for (int i = 0; i < 10; i++) write_gain(i, (i == 3) ? 8192 : 0, 1'b0);
    fill(0); bv[3] = 1001;
    start_mix(); wait_idle();
    bv[3] = -1001;
    start_mix(); wait_idle();

    // Saturation at both rails
    for (int i = 0; i < 10; i++) write_gain(i, 16384, 1'b0);
    fill(8388607);
    start_mix(); wait_idle();
    fill(-8388608);
    start_mix(); wait_idle();

    // New strobe accepted in the valid cycle
    fill(1000);
    start_mix();
    repeat (11) tick();
    check("valid_cycle", o_valid, 1);
    fill(7);
    start_mix(); wait_idle();

    // Overrun: second strobe at E5 is dropped
    fill(1000);
    start_mix();
    repeat (4) tick();
    for (int i = 0; i < 10; i++) band[i] = 24'd2000;
    en = 1'b1;
    tick();
    en = 1'b0;
    check("o_drop_pulse", o_drop, 1);
    tick();
    check("o_drop_clear", o_drop, 0);
    wait_idle();

    // Gain write during MAC is rejected
    fill(1000);
    start_mix();
    repeat (2) tick();
    write_gain(2, 0, 1'b1);
    tick();
    check("o_wr_err_clear", o_wr_err, 0);
    wait_idle();
    start_mix(); wait_idle();

    // Out-of-range address is rejected in IDLE
    write_gain(12, 5, 1'b0);
    start_mix(); wait_idle();

    // Gain write in the same cycle as capture applies to that capture
    gwe = 1'b1; gaddr = 4'd0; gdata = 16'hC000;
    gm[0] = -16384;
    fill(1000);
    start_mix();
    gwe = 1'b0;
    check("simul_wr_err", o_wr_err, 0);
    wait_idle();

    // Reset mid-mix aborts and restores unity gains
    fill(1000);
    start_mix();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbq.delete();
    set_unity();
    check_zero_outputs("midreset");
    repeat (15) tick();
    start_mix(); wait_idle();

    // Random gains and bands
    for (int it = 0; it < 40; it++) begin
      nb = $urandom_range(0, 2);
      for (int w = 0; w < nb; w++) begin
        t16 = 16'($urandom);
        if ($urandom_range(0, 1) == 0) t16 = 16'($urandom_range(0, 32767) - 16384);
        write_gain($urandom_range(0, 15), int'($signed(t16)), 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
        t24 = 24'($urandom);
        if ($urandom_range(0, 3) != 0) t24 = 24'($urandom_range(0, 400000) - 200000);
        bv[i] = int'($signed(t24));
      end
      start_mix();
      wait_idle();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
